uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Receives the program image that the bench drives serially into user-project pin mprj_io[5] as 8N1 UART frames.
- Assembles the frames into 32-bit little-endian instruction words and writes them sequentially into instruction memory.
- Holds the downstream core in reset until a terminating word arrives.
- Sits between the mprj_io[5] pad input and the instruction-memory write port / core reset.

Parameters:
- CLKS_PER_BIT, 434, wb_clk_i cycles per UART bit (integer ≥ 4).
- ADDR_W, 13, instruction-memory word-address width.
- END_WORD, 32'h00000FFF, terminating word; never written to memory.

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- rx_i  in  1  serial input from mprj_io[5]; asynchronous, idles high.
- en_i  in  1  loader enable.
- mem_we_o  out  1  one-cycle memory write strobe.
- mem_addr_o  out  ADDR_W  word address of the current write.
- mem_wdata_o  out  32  write data.
- word_count_o  out  ADDR_W+1  number of words written so far.
- busy_o  out  1  frame or partial word in progress.
- done_o  out  1  sticky; END_WORD received or memory full.
- ovf_o  out  1  sticky; memory-full termination.
- frame_err_o  out  1  sticky; a stop bit was sampled low.
- core_rst_o  out  1  core reset; equals !done_o.

Behaviour:
- Reset values:
  - mem_we_o, mem_addr_o, mem_wdata_o, word_count_o, busy_o, done_o, ovf_o, frame_err_o = 0.
  - core_rst_o = 1.
  - RX FSM = IDLE; byte index = 0.
- Input synchronisation: rx_i passes through a 2-flop synchroniser. All sampling uses the synchronised value rx_s.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_s == 0 and en_i == 1, go to START with the bit counter cleared.
  - START: at count CLKS_PER_BIT/2 - 1, re-sample rx_s. If still 0, go to DATA. If 1, treat as a glitch and return to IDLE with no effect.
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx_s == 1: pulse internal byte_valid for 1 cycle, then go to IDLE.
    - rx_s == 0: set frame_err_o, discard the byte, leave the byte index unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once rx_s == 1.
- Word assembly:
  - Byte k (k = 0..3) loads bits [8k+7:8k] of the word register.
  - On the 4th byte_valid, the byte index wraps to 0 and the word is evaluated on the next cycle.
- Word evaluation:
  - word == END_WORD: set done_o; no write.
  - Otherwise, for exactly 1 cycle: mem_we_o = 1, mem_wdata_o = word, mem_addr_o = word_count_o[ADDR_W-1:0]. word_count_o increments on the same edge.
  - Latency: mem_we_o rises 2 cycles after the 4th byte's stop-bit sample edge.
- Memory full:
  - The write to address 2^ADDR_W - 1 sets ovf_o and done_o on the same edge.
  - Addresses never wrap.
- Once done_o = 1:
  - RX FSM is forced to IDLE; all further input is ignored; no writes occur.
  - done_o stays high until wb_rst_i.
- en_i deasserted:
  - RX FSM returns to IDLE and any partial byte is dropped.
  - Byte index is cleared, so any partial word is dropped.
  - word_count_o and the sticky flags are retained.
- busy_o = !done_o && (RX FSM != IDLE || byte index != 0).
- wb_rst_i mid-frame or mid-word aborts everything immediately to the reset values; the next frame starts a new word at address 0.

Test Plan (CLKS_PER_BIT = 8, ADDR_W = 4 unless noted):
1. Send bytes 0x13, 0x05, 0x00, 0x00 → exactly one mem_we_o pulse with addr 0, data 0x00000513, 2 cycles after the last stop-bit sample; word_count_o = 1; core_rst_o stays 1.
2. Send words 0x00000513, 0x00100093, 0x0000006F, then bytes FF 0F 00 00, then 4 more bytes → writes to addr 0, 1, 2 only; done_o = 1 and core_rst_o = 0 after the terminator; no further mem_we_o.
3. Pulse rx_i low for 2 cycles, then hold high → no byte_valid, no write, frame_err_o = 0, busy_o returns to 0.
4. Send byte 0x13 with its stop bit held low for 8 cycles, then send bytes 0x13, 0x05, 0x00, 0x00 normally → frame_err_o = 1; single write with data 0x00000513 to addr 0.
5. Stream 16 non-terminating words → writes to addr 0..15; ovf_o = done_o = 1 on the 16th write; word_count_o = 16; a 17th word produces no write.
6. Send 2 bytes, assert wb_rst_i for 1 cycle mid-3rd frame, then send AA BB CC DD → all outputs at reset values after the reset edge; then a single write with addr 0, data 0xDDCCBBAA.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes on a pad input, packs them into
// little-endian 32-bit words, writes them sequentially into instruction
// memory and releases the core reset once a terminating word arrives or the
// memory is full.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          ADDR_W       = 13,
    parameter logic [31:0] END_WORD     = 32'h00000FFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    input  logic              en_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic              frame_err_o,
    output logic              core_rst_o
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Synchroniser stages
    logic rx_meta_q;
    logic rx_s_q;

    // Receiver state
    rx_state_e        state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [7:0]       shift_q,      shift_d;
    logic             byte_valid_q, byte_valid_d;

    // Word assembly and write-port state
    logic [1:0]        byte_idx_q,  byte_idx_d;
    logic [31:0]       word_q,      word_d;
    logic              eval_q,      eval_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic              done_q,      done_d;
    logic              ovf_q,       ovf_d;
    logic              frame_err_q, frame_err_d;

    // Two-flop synchroniser for the asynchronous pad input; idles high.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver next-state: start-bit qualification, mid-bit sampling, stop check.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        if (done_q || !en_i) begin
            // Loader finished or disabled: park the receiver, drop any partial byte.
            state_d   = S_IDLE;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                        // A line that is high again mid start bit was only a glitch.
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            byte_valid_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_HIGH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Word assembly, evaluation of completed words and memory write generation.
    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        eval_d     = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        if (!en_i) begin
            byte_idx_d = 2'd0;
        end else if (byte_valid_q && !done_q) begin
            word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
            byte_idx_d                        = byte_idx_q + 2'd1;
            eval_d                            = (byte_idx_q == 2'd3);
        end else begin
            byte_idx_d = byte_idx_q;
        end

        if (eval_q && !done_q) begin
            if (word_q == END_WORD) begin
                done_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = word_q;
                count_d = count_q + (ADDR_W + 1)'(1'b1);
                // The last address ends the load; the address never wraps.
                if (count_q[ADDR_W-1:0] == LAST_ADDR) begin
                    ovf_d  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end
        end else begin
            we_d = 1'b0;
        end
    end

    // State register for the receiver, assembler and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'h0000_0000;
            eval_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            count_q      <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            eval_q       <= eval_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            count_q      <= count_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign word_count_o = count_q;
    assign done_o       = done_q;
    assign ovf_o        = ovf_q;
    assign frame_err_o  = frame_err_q;
    assign core_rst_o   = !done_q;
    assign busy_o       = !done_q && ((state_q != S_IDLE) || (byte_idx_q != 2'd0));

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader with a byte/word-level reference model.
module tb_uart_prog_loader;

    localparam int          CPB         = 8;
    localparam int          AW          = 4;
    localparam logic [31:0] END_WORD    = 32'h00000FFF;
    // Stop-bit sample edge relative to the edge before the start bit is driven:
    // 2 synchroniser flops + 1 detect edge + half a bit + 9 full bits.
    localparam int          STOP_SAMPLE = 3 + CPB / 2 + 9 * CPB;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          rx_i = 1'b1;
    logic          en_i = 1'b1;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [AW:0]   word_count_o;
    logic          busy_o, done_o, ovf_o, frame_err_o, core_rst_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'd0;

    // Reference model state
    logic [7:0]  mbytes[$];
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [31:0] mcount;
    bit          mdone, movf;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .END_WORD(END_WORD)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .rx_i(rx_i), .en_i(en_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .word_count_o(word_count_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
        .frame_err_o(frame_err_o), .core_rst_o(core_rst_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Record every cycle the write strobe is seen high.
    always @(negedge clk) begin
        if (mem_we_o === 1'b1) obs_q.push_back('{cyc: cyc, addr: mem_addr_o, data: mem_wdata_o});
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mbytes.delete();
        exp_q.delete();
        obs_q.delete();
        mcount = 32'd0;
        mdone  = 1'b0;
        movf   = 1'b0;
    endtask

    // A correctly framed byte as the spec's word/memory rules see it.
    task automatic model_byte(input logic [7:0] b, input logic [31:0] t0);
        logic [31:0] w;
        if (mdone) return;
        mbytes.push_back(b);
        if (mbytes.size() == 4) begin
            w = {mbytes[3], mbytes[2], mbytes[1], mbytes[0]};
            mbytes.delete();
            if (w == END_WORD) begin
                mdone = 1'b1;
            end else begin
                exp_q.push_back('{cyc: t0 + STOP_SAMPLE + 2, addr: mcount[AW-1:0], data: w});
                mcount = mcount + 32'd1;
                if (mcount == (32'd1 << AW)) begin
                    mdone = 1'b1;
                    movf  = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        wb_rst_i = 1'b1;
        rx_i     = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        model_reset();
    endtask

    // Drive one 8N1 frame; a low stop bit is held for one bit time then released.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [31:0] t0;
        @(posedge clk); #1;
        t0   = cyc;
        rx_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk); #1;
            rx_i = b[i];
        end
        repeat (CPB) @(posedge clk); #1;
        rx_i = stop_ok;
        repeat (CPB) @(posedge clk); #1;
        rx_i = 1'b1;
        if (stop_ok) model_byte(b, t0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        model_reset();
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we_o); end
        checks++; if (mem_addr_o !== 4'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
        checks++; if (mem_wdata_o !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata_o); end
        checks++; if (word_count_o !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", word_count_o); end
        checks++; if ({busy_o, done_o, ovf_o, frame_err_o} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {busy_o, done_o, ovf_o, frame_err_o}); end
        checks++; if (core_rst_o !== 1'b1) begin errors++; $display("FAIL rst_core: got %b want 1", core_rst_o); end
    endtask

    task automatic test_single_word();
        do_reset();
        idle(4);
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        idle(4 * CPB);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_nwr: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_wr%0d: got cyc %0d addr %h data %h want cyc %0d addr %h data %h", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data); end
        end
        checks++; if (exp_q.size() > 0 && exp_q[0].data !== 32'h0000_0513) begin errors++; $display("FAIL single_model: got %h want 00000513", exp_q[0].data); end
        checks++; if (word_count_o !== mcount[AW:0]) begin errors++; $display("FAIL single_count: got %0d want %0d", word_count_o, mcount); end
        checks++; if (core_rst_o !== 1'b1) begin errors++; $display("FAIL single_core: got %b want 1", core_rst_o); end
    endtask

    task automatic test_terminator();
        do_reset();
        idle(4);
        send_word(32'h0000_0513); send_word(32'h0010_0093); send_word(32'h0000_006F);
        send_word(END_WORD);
        idle(4);
        checks++; if (done_o !== 1'b1 || core_rst_o !== 1'b0) begin errors++; $display("FAIL term_done: got done %b core_rst %b want 1 0", done_o, core_rst_o); end
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        idle(4 * CPB);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL term_nwr: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL term_wr%0d: got addr %h data %h want addr %h data %h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data); end
        end
        checks++; if (word_count_o !== 5'd3 || ovf_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL term_state: got count %0d ovf %b busy %b want 3 0 0", word_count_o, ovf_o, busy_o); end
    endtask

    task automatic test_glitch();
        do_reset();
        idle(4);
        rx_i = 1'b0;
        idle(2);
        rx_i = 1'b1;
        idle(3 * CPB);
        checks++; if (busy_o !== 1'b0 || frame_err_o !== 1'b0) begin errors++; $display("FAIL glitch_flags: got busy %b ferr %b want 0 0", busy_o, frame_err_o); end
        send_word(32'hCAFE_0123);
        idle(4 * CPB);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL glitch_nwr: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_wr%0d: got addr %h data %h want addr %h data %h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data); end
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        idle(4);
        send_byte(8'h13, 1'b0);
        idle(2 * CPB);
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", frame_err_o); end
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        idle(4 * CPB);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL ferr_nwr: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ferr_wr%0d: got cyc %0d addr %h data %h want cyc %0d addr %h data %h", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data); end
        end
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b want 1", frame_err_o); end
    endtask

    task automatic test_enable();
        do_reset();
        idle(4);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        idle(4);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL en_busy: got %b want 1", busy_o); end
        en_i = 1'b0;
        mbytes.delete();
        idle(4);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL en_idle: got %b want 0", busy_o); end
        en_i = 1'b1;
        send_word($urandom() | 32'h8000_0000);
        idle(4 * CPB);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL en_nwr: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL en_wr%0d: got addr %h data %h want addr %h data %h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        idle(4);
        for (int w = 0; w < 17; w++) send_word($urandom() | 32'h0001_0000);
        idle(4 * CPB);
        checks++; if (obs_q.size() !== exp_q.size() || exp_q.size() != 16) begin errors++; $display("FAIL ovf_nwr: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_wr%0d: got cyc %0d addr %h data %h want cyc %0d addr %h data %h", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data); end
        end
        checks++; if ({ovf_o, done_o, core_rst_o} !== {movf, mdone, !mdone}) begin errors++; $display("FAIL ovf_flags: got ovf %b done %b core_rst %b want %b %b %b", ovf_o, done_o, core_rst_o, movf, mdone, !mdone); end
        checks++; if (word_count_o !== mcount[AW:0]) begin errors++; $display("FAIL ovf_count: got %0d want %0d", word_count_o, mcount); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        idle(4);
        n = $urandom_range(3, 6);
        for (int w = 0; w < n; w++) send_word($urandom());
        idle(4 * CPB);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_nwr: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_wr%0d: got cyc %0d addr %h data %h want cyc %0d addr %h data %h", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data); end
        end
        checks++; if (word_count_o !== mcount[AW:0] || done_o !== mdone) begin errors++; $display("FAIL b2b_state: got count %0d done %b want %0d %b", word_count_o, done_o, mcount, mdone); end
    endtask

    // Runs straight after test_back_to_back so the outputs hold non-reset values.
    task automatic test_reset_mid();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        @(posedge clk); #1;
        rx_i = 1'b0;
        idle(3 * CPB);
        wb_rst_i = 1'b1;
        rx_i     = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        model_reset();
        checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o, word_count_o} !== {1'b0, 4'd0, 32'd0, 5'd0}) begin errors++; $display("FAIL mid_rst_wr: got we %b addr %h data %h count %0d want 0 0 0 0", mem_we_o, mem_addr_o, mem_wdata_o, word_count_o); end
        checks++; if ({busy_o, done_o, ovf_o, frame_err_o, core_rst_o} !== 5'b00001) begin errors++; $display("FAIL mid_rst_flags: got %b want 00001", {busy_o, done_o, ovf_o, frame_err_o, core_rst_o}); end
        idle(2 * CPB);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        idle(4 * CPB);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL mid_nwr: got %0d want 1", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_wr%0d: got addr %h data %h want addr %h data %h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data); end
        end
        checks++; if (obs_q.size() > 0 && obs_q[0].data !== 32'hDDCC_BBAA) begin errors++; $display("FAIL mid_data: got %h want ddccbbaa", obs_q[0].data); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_terminator();
        test_glitch();
        test_frame_err();
        test_enable();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
